// File: rtl/capture_seq.sv
// Pre/post-trigger ring-buffer capture sequencer: issues 16-byte PSRAM write bursts.
// Optional periodic re-capture after a DONE dwell: define CAPTURE_AUTO_REARM_EN.
module capture_seq #(
    parameter int unsigned RING_AW     = 20,
    parameter int unsigned PRE_BURSTS  = 64,
    parameter int unsigned POST_BURSTS = 1024,
    parameter int unsigned HOLD_CYCLES = 48000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic        trigger,
    input  logic        psram_ready,
    input  logic        almost_empty,
    input  logic        awready,
    output logic        awvalid,
    output logic [24:0] awaddr,
    output logic [24:0] base_addr,
    output logic        armed,
    output logic        capture_done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefill = 3'd1,
        StArmed   = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam int unsigned PRE_W  = (PRE_BURSTS > 0) ? $clog2(PRE_BURSTS + 1) : 1;
    localparam int unsigned POST_W = (POST_BURSTS > 0) ? $clog2(POST_BURSTS + 1) : 1;
    localparam logic [RING_AW-1:0] BURST_BYTES = RING_AW'(16);
    localparam logic [RING_AW-1:0] PRE_OFFSET  = RING_AW'(16 * PRE_BURSTS);

    if ((RING_AW < 5) || (RING_AW > 25) || (HOLD_CYCLES == 0) ||
        (PRE_BURSTS + POST_BURSTS > (32'd1 << (RING_AW - 4)))) begin : g_bad_params
        $error("capture_seq: invalid parameter set");
    end

    state_e               r_state, w_state_d;
    logic                 r_trig;
    logic                 r_awvalid, w_awvalid_d;
    logic [RING_AW-1:0]   r_awaddr, w_awaddr_d;
    logic [RING_AW-1:0]   r_base, w_base_d;
    logic [PRE_W-1:0]     r_pre, w_pre_d;
    logic [POST_W-1:0]    r_post, w_post_d;
    logic                 r_arm_pend, w_arm_pend_d;
    logic                 w_hs, w_trig_edge, w_active, w_arm_req, w_start;
`ifdef CAPTURE_AUTO_REARM_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    logic [HOLD_W-1:0]    r_hold, w_hold_d;
`endif

    assign w_hs        = r_awvalid & awready;
    assign w_trig_edge = trigger & ~r_trig;
    assign w_active    = (r_state == StPrefill) || (r_state == StArmed) || (r_state == StPost);
    assign w_arm_req   = arm | r_arm_pend;

    always_comb begin
        w_state_d    = r_state;
        w_awaddr_d   = r_awaddr;
        w_base_d     = r_base;
        w_pre_d      = r_pre;
        w_post_d     = r_post;
        w_arm_pend_d = r_arm_pend;
        w_start      = 1'b0;
        w_awvalid_d  = r_awvalid ? ~w_hs : (w_active & ~almost_empty);
`ifdef CAPTURE_AUTO_REARM_EN
        w_hold_d     = r_hold;
`endif
        if ((r_state != StIdle) && !psram_ready) begin
            w_state_d    = StIdle;
            w_awvalid_d  = 1'b0;
            w_arm_pend_d = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (arm && psram_ready) w_start = 1'b1;
                end
                StDone: begin
                    if (arm) w_start = 1'b1;
`ifdef CAPTURE_AUTO_REARM_EN
                    else if (r_hold <= HOLD_W'(1)) w_start = 1'b1;
                    else w_hold_d = r_hold - HOLD_W'(1);
`endif
                end
                StPrefill, StArmed, StPost: begin
                    // An outstanding request finishes to its old address before restarting.
                    if (w_arm_req) begin
                        if (r_awvalid && !w_hs) w_arm_pend_d = 1'b1;
                        else w_start = 1'b1;
                    end else if ((r_state == StArmed) && w_trig_edge) begin
                        w_base_d  = r_awaddr - PRE_OFFSET;
                        w_post_d  = POST_W'(POST_BURSTS);
                        w_state_d = StPost;
                        if (w_hs) begin
                            w_awaddr_d = r_awaddr + BURST_BYTES;
                            w_post_d   = POST_W'(POST_BURSTS - 1);
                            if (POST_BURSTS == 1) w_state_d = StDone;
                        end
                    end else if (w_hs) begin
                        w_awaddr_d = r_awaddr + BURST_BYTES;
                        if (r_state == StPrefill) begin
                            w_pre_d = r_pre + PRE_W'(1);
                            if (r_pre + PRE_W'(1) == PRE_W'(PRE_BURSTS)) w_state_d = StArmed;
                        end else if (r_state == StPost) begin
                            w_post_d = r_post - POST_W'(1);
                            if (r_post == POST_W'(1)) w_state_d = StDone;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
        if (w_start) begin
            w_state_d    = StPrefill;
            w_awaddr_d   = '0;
            w_pre_d      = '0;
            w_post_d     = '0;
            w_arm_pend_d = 1'b0;
        end
`ifdef CAPTURE_AUTO_REARM_EN
        if ((w_state_d == StDone) && (r_state != StDone)) w_hold_d = HOLD_W'(HOLD_CYCLES);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_trig     <= 1'b1;
            r_awvalid  <= 1'b0;
            r_awaddr   <= '0;
            r_base     <= '0;
            r_pre      <= '0;
            r_post     <= '0;
            r_arm_pend <= 1'b0;
`ifdef CAPTURE_AUTO_REARM_EN
            r_hold     <= '0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_trig     <= trigger;
            r_awvalid  <= w_awvalid_d;
            r_awaddr   <= w_awaddr_d;
            r_base     <= w_base_d;
            r_pre      <= w_pre_d;
            r_post     <= w_post_d;
            r_arm_pend <= w_arm_pend_d;
`ifdef CAPTURE_AUTO_REARM_EN
            r_hold     <= w_hold_d;
`endif
        end
    end

    assign awvalid      = r_awvalid;
    assign awaddr       = 25'(r_awaddr);
    assign base_addr    = 25'(r_base);
    assign armed        = (r_state == StArmed);
    assign capture_done = (r_state == StDone);
    assign state        = r_state;

endmodule

// File: tb/tb_capture_seq.sv
// Directed bench for capture_seq; burst addresses are checked against a scoreboard queue.
module tb_capture_seq;

    logic        clk = 1'b0;
    logic        reset_n, arm, trigger, psram_ready, almost_empty, awready;
    logic        awvalid, armed, capture_done;
    logic [24:0] awaddr, base_addr;
    logic [2:0]  state;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_hs     = 0;
    bit          rdy_en   = 1'b1;
    logic [24:0] exp_q[$];

    capture_seq #(
        .RING_AW    (8),
        .PRE_BURSTS (4),
        .POST_BURSTS(6),
        .HOLD_CYCLES(10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .arm         (arm),
        .trigger     (trigger),
        .psram_ready (psram_ready),
        .almost_empty(almost_empty),
        .awready     (awready),
        .awvalid     (awvalid),
        .awaddr      (awaddr),
        .base_addr   (base_addr),
        .armed       (armed),
        .capture_done(capture_done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: score any handshake in the current cycle, then advance past the edge.
    task automatic tick();
        logic [24:0] e;
        if (awvalid === 1'b1 && awready === 1'b1) begin
            n_hs++;
            e = (exp_q.size() == 0) ? 25'h1ffffff : exp_q.pop_front();
            check("hs_addr", awaddr, e);
            exp_q.push_back((e + 25'd16) & 25'h0ff);
        end
        @(posedge clk);
        #1;
        awready = rdy_en ? ~awready : 1'b0;
    endtask

    task automatic wait_hs(input int n, input string tag);
        int target = n_hs + n;
        for (int c = 0; c < 200 && n_hs < target; c++) tick();
        check(tag, n_hs, target);
    endtask

    task automatic start_capture();
        exp_q.delete();
        exp_q.push_back(25'h0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        int          bad;
        int          n;
        logic [24:0] e;
        reset_n = 1'b0; arm = 1'b0; trigger = 1'b0; psram_ready = 1'b1;
        almost_empty = 1'b0; awready = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_base", base_addr, 0);
        check("rst_flags", {armed, capture_done}, 0);
        reset_n = 1'b1;
        tick();

        // Prefill four bursts, then armed at 0x40
        start_capture();
        check("arm_prefill", state, 1);
        wait_hs(4, "fill_hs");
        check("fill_state", state, 2);
        check("fill_armed", armed, 1);
        check("fill_awaddr", awaddr, 25'h040);

        // Wrap through 0xF0 -> 0x00, trigger on a non-handshake cycle at 0x20
        wait_hs(14, "wrap_hs");
        check("wrap_state", state, 2);
        check("wrap_awaddr", awaddr, 25'h020);
        check("wrap_awvalid_low", awvalid, 0);
        trigger = 1'b1;
        tick();
        check("trig_state", state, 3);
        check("trig_base", base_addr, 25'h0e0);
        trigger = 1'b0;
        wait_hs(5, "post5_hs");
        check("post5_state", state, 3);
        wait_hs(1, "post6_hs");
        check("done_state", state, 4);
        check("done_flag", capture_done, 1);
        check("done_awaddr", awaddr, 25'h080);
        bad = 0;
        repeat (5) begin
            tick();
            if (awvalid !== 1'b0 || awaddr !== 25'h080) bad++;
        end
        check("done_quiet", bad, 0);

        // Trigger edge coinciding with a handshake at 0x30
        start_capture();
        check("rearm_state", state, 1);
        check("rearm_awaddr", awaddr, 0);
        check("rearm_base_held", base_addr, 25'h0e0);
        wait_hs(4, "fill2_hs");
        wait_hs(15, "lap_hs");
        for (int c = 0; c < 10 && !(awvalid && awready); c++) tick();
        check("sim_hs_ready", {awvalid, awready}, 2'b11);
        check("sim_awaddr", awaddr, 25'h030);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("sim_state", state, 3);
        check("sim_base", base_addr, 25'h0f0);
        check("sim_awaddr_inc", awaddr, 25'h040);
        wait_hs(4, "sim_post4_hs");
        check("sim_post4_state", state, 3);
        wait_hs(1, "sim_post5_hs");
        check("sim_done_state", state, 4);
        check("sim_done_awaddr", awaddr, 25'h090);

        // Backpressure: request must hold still while awready is low
        rdy_en = 1'b0;
        awready = 1'b0;
        start_capture();
        for (int c = 0; c < 10 && awvalid !== 1'b1; c++) tick();
        check("bp_awvalid", awvalid, 1);
        bad = 0;
        repeat (20) begin
            tick();
            if (awvalid !== 1'b1 || awaddr !== 25'h0) bad++;
        end
        check("bp_stable", bad, 0);
        rdy_en = 1'b1;
        awready = 1'b1;
        almost_empty = 1'b1;
        wait_hs(1, "ae_hs");
        bad = 0;
        repeat (10) begin
            tick();
            if (awvalid !== 1'b0) bad++;
        end
        check("ae_no_req", bad, 0);
        almost_empty = 1'b0;
        wait_hs(3, "ae_fill_hs");
        check("ae_state", state, 2);
        check("ae_awaddr", awaddr, 25'h040);

        // Abort in POST, then arm without a ready controller
        wait_hs(1, "abort_pre_hs");
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("abort_post", state, 3);
        check("abort_base", base_addr, 25'h010);
        wait_hs(2, "abort_hs");
        psram_ready = 1'b0;
        tick();
        check("abort_state", state, 0);
        check("abort_awvalid", awvalid, 0);
        check("abort_base_kept", base_addr, 25'h010);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        check("arm_noready", state, 0);
        psram_ready = 1'b1;
        tick();
        check("arm_not_latched", state, 0);

        // Trigger already high across reset release must not fire
        reset_n = 1'b0;
        trigger = 1'b1;
        repeat (3) tick();
        check("rst2_base", base_addr, 0);
        reset_n = 1'b1;
        tick();
        start_capture();
        wait_hs(4, "hi_fill_hs");
        bad = 0;
        repeat (12) begin
            tick();
            if (state !== 3'd2) bad++;
        end
        check("hi_no_trigger", bad, 0);
        trigger = 1'b0;
        tick();
        e = exp_q[0];
        trigger = 1'b1;
        tick();
        check("hi_post", state, 3);
        check("hi_base", base_addr, (e - 25'h040) & 25'h0ff);
        for (int c = 0; c < 60 && state !== 3'd4; c++) tick();
        check("hi_done", state, 4);

`ifdef CAPTURE_AUTO_REARM_EN
        n = 0;
        while (state === 3'd4 && n < 100) begin
            n++;
            tick();
        end
        check("hold_cycles", n, 10);
        check("hold_rearm_state", state, 1);
        check("hold_rearm_awaddr", awaddr, 0);
`else
        n = 0;
        repeat (1000) begin
            tick();
            if (state !== 3'd4) n++;
        end
        check("done_persist", n, 0);
        check("done_persist_flag", capture_done, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/capture_seq.md
Name: capture_seq

Overview:
- Sequences ADC capture into PSRAM as a pre/post-trigger ring buffer.
- Sits between the ADC write FIFO and the psram_ctrl AXI write-address channel.
- Issues 16-byte burst write requests; each burst holds 8 x 16-bit words (two 4-channel sample sets).
- Freezes the ring after a trigger and publishes base_addr, so the HDMI #2 readback starts PRE_BURSTS bursts before the trigger.

Parameters:
- RING_AW, 20, log2 of ring size in bytes. Ring occupies byte addresses 0 .. 2^RING_AW-1. Must be 5..25.
- PRE_BURSTS, 64, bursts retained before the trigger.
- POST_BURSTS, 1024, bursts written after the trigger, counting the trigger burst.
- HOLD_CYCLES, 48000000, DONE dwell in clk cycles. Used only with CAPTURE_AUTO_REARM_EN.
- Constraint: PRE_BURSTS + POST_BURSTS <= 2^(RING_AW-4). Elaboration-time check.

Ports:
- clk  in  1  system clock (48 MHz ADC domain).
- reset_n  in  1  synchronous active-low reset.
- arm  in  1  single-cycle pulse: start or restart a capture.
- trigger  in  1  level (pwm); its rising edge is the trigger event.
- psram_ready  in  1  memory controller initialised.
- almost_empty  in  1  write FIFO holds fewer than 8 words.
- awready  in  1  AXI write-address ready.
- awvalid  out  1  AXI write-address valid.
- awaddr  out  25  burst byte address, 16-byte aligned.
- base_addr  out  25  address of the first retained pre-trigger burst.
- armed  out  1  high in ARMED state.
- capture_done  out  1  high in DONE state.
- state  out  3  encoded state: IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.

Behaviour:
- Reset: all outputs and counters are 0 and state=IDLE. trig_q (registered trigger) is reset to 1 so a trigger already high at reset does not count as an edge.
- Edge detect: trig_edge = trigger & !trig_q, where trig_q is trigger registered once.
- Handshake (hs) = awvalid & awready.
  - On hs: awaddr <= (awaddr + 16) mod 2^RING_AW; bits [24:RING_AW] stay 0.
  - Wrap: from 2^RING_AW-16 to 0.
- awvalid rule:
  - Asserts the cycle after (state in PREFILL/ARMED/POST) & !almost_empty & !awvalid.
  - Once high, holds until hs, except on psram_ready drop or reset.
  - Deasserts the cycle after hs, giving at most one outstanding request.
- IDLE:
  - arm & psram_ready -> PREFILL; awaddr <= 0; pre_cnt <= 0.
  - arm while psram_ready=0 is ignored.
- PREFILL:
  - Each hs increments pre_cnt.
  - When hs brings pre_cnt to PRE_BURSTS -> ARMED.
  - trig_edge is ignored.
- ARMED:
  - Writes continue and the ring wraps freely.
  - On trig_edge: base_addr <= (awaddr - 16*PRE_BURSTS) mod 2^RING_AW, using awaddr before any same-cycle hs increment; post_cnt <= POST_BURSTS; go to POST.
  - A hs in the same cycle as the edge is still counted into post_cnt (decrement applied).
- POST:
  - Each hs decrements post_cnt.
  - hs with post_cnt==1 -> DONE. awvalid is low from the next cycle.
  - trig_edge is ignored.
- DONE:
  - No write requests; awaddr and base_addr are frozen; capture_done=1.
  - arm -> PREFILL (awaddr <= 0, pre_cnt <= 0). base_addr holds its value until the next trigger.
- arm in PREFILL, ARMED or POST restarts: next state PREFILL, awaddr <= 0, counters cleared.
  - If awvalid is high, it stays high and the hs completes to the old address before the restart applies. The restart is taken on the cycle of that hs.
- psram_ready low in any non-IDLE state -> IDLE next cycle; awvalid <= 0; base_addr kept.
- Priority within one cycle: reset > psram_ready drop > arm > trig_edge > hs.
- The FIFO read side is not controlled here; psram_ctrl pulls wready.

Optional Feature:
- Macro: CAPTURE_AUTO_REARM_EN.
- Defined: DONE loads a hold counter with HOLD_CYCLES. When the counter reaches 0 -> PREFILL (awaddr <= 0), giving periodic captures. arm still takes effect immediately.
- Undefined: DONE persists until arm or a psram_ready drop. HOLD_CYCLES is unused and no hold counter is synthesised.

Test Plan:
Bench parameters: RING_AW=8 (16 bursts), PRE_BURSTS=4, POST_BURSTS=6, almost_empty=0, awready=1 every other cycle.
- Fill: arm pulse -> state 1. After 4 hs: state 2, awaddr=0x040.
- Wrap and trigger: stay in ARMED until awaddr reaches 0xF0 (next 0x00), then trigger edge at awaddr=0x020 -> base_addr=0x0E0, state 3. After 6 hs: state 4, awaddr=0x080, awvalid=0 thereafter.
- Simultaneous events:
  - Trigger edge on a hs cycle with awaddr=0x030 -> base_addr=0x1F0 mod 256=0x0F0. DONE after 5 further hs.
  - Trigger high at reset release -> no trigger taken.
- Backpressure: awready=0 for 20 cycles with awvalid=1 -> awvalid and awaddr stable throughout. almost_empty=1 -> no new awvalid.
- Abort: psram_ready=0 in POST -> state 0, awvalid=0, base_addr unchanged. arm with psram_ready=0 -> stays state 0.
- Auto-rearm: with the macro defined and HOLD_CYCLES=10, DONE -> PREFILL after exactly 10 cycles. Without the macro, the state remains 4 for 1000 cycles.
